// File: rtl/vproc_result_pack.sv
// Result packer: gathers full- and half-width result chunks into one vector
// register image and hands completed groups to the register file.
`timescale 1ns/1ps
module vproc_result_pack #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned OP_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [OP_W-1:0]       res_data_i,
    input  logic [OP_W/8-1:0]     res_be_i,
    input  logic                  res_narrow_i,
    input  logic                  res_last_i,
    input  logic [4:0]            res_vaddr_i,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [4:0]            wr_addr_o,
    output logic [VREG_W-1:0]     wr_data_o,
    output logic [VREG_W/8-1:0]   wr_be_o,
    output logic                  busy_o
);
    localparam int unsigned SLOTS = 2 * VREG_W / OP_W;
    localparam int unsigned HW    = OP_W / 2;
    localparam int unsigned HB    = OP_W / 16;
    localparam int unsigned PTR_W = $clog2(SLOTS);

    logic [PTR_W-1:0]    ptr_reg, ptr_next;
    logic [VREG_W-1:0]   acc_data_reg, acc_data_next;
    logic [VREG_W/8-1:0] acc_be_reg, acc_be_next;
    logic [4:0]          acc_addr_reg, acc_addr_next;
    logic                acc_done_reg, acc_done_next;
    logic [VREG_W-1:0]   out_data_reg, out_data_next;
    logic [VREG_W/8-1:0] out_be_reg, out_be_next;
    logic [4:0]          out_addr_reg, out_addr_next;
    logic                out_valid_reg, out_valid_next;

    logic                xfer, no_fit, accept, split, complete;
    logic [PTR_W:0]      wr_slot, hi_slot, end_slot;
    logic [VREG_W-1:0]   base_data;
    logic [VREG_W/8-1:0] base_be;

    assign xfer        = acc_done_reg && (!out_valid_reg || wr_ready_i);
    // A full-width chunk cannot start in the final half slot; it closes the group instead.
    assign no_fit      = (ptr_reg == PTR_W'(SLOTS - 1)) && !res_narrow_i;
    assign res_ready_o = (!acc_done_reg || xfer) && !no_fit;
    assign accept      = res_valid_i && res_ready_o;
    assign split       = res_valid_i && no_fit;

    assign wr_slot   = {1'b0, ptr_reg} + (PTR_W+1)'(!res_narrow_i && ptr_reg[0]);
    assign hi_slot   = wr_slot + (PTR_W+1)'(1);
    assign end_slot  = wr_slot + (res_narrow_i ? (PTR_W+1)'(1) : (PTR_W+1)'(2));
    assign complete  = res_last_i || (end_slot == (PTR_W+1)'(SLOTS));
    assign base_data = xfer ? '0 : acc_data_reg;
    assign base_be   = xfer ? '0 : acc_be_reg;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic lo_hit, hi_hit;
            assign lo_hit = accept && (wr_slot == (PTR_W+1)'(gi));
            assign hi_hit = accept && !res_narrow_i && (hi_slot == (PTR_W+1)'(gi));
            assign acc_data_next[gi*HW +: HW] = lo_hit ? res_data_i[HW-1:0]
                                              : hi_hit ? res_data_i[OP_W-1:HW]
                                              : base_data[gi*HW +: HW];
            assign acc_be_next[gi*HB +: HB]   = lo_hit ? res_be_i[HB-1:0]
                                              : hi_hit ? res_be_i[2*HB-1:HB]
                                              : base_be[gi*HB +: HB];
        end
    endgenerate

    always_comb begin
        ptr_next      = ptr_reg;
        acc_addr_next = acc_addr_reg;
        acc_done_next = acc_done_reg;
        if (xfer) begin
            acc_done_next = 1'b0;
        end
        if (accept) begin
            if (ptr_reg == '0) begin
                acc_addr_next = res_vaddr_i;
            end
            if (complete) begin
                ptr_next      = '0;
                acc_done_next = 1'b1;
            end else begin
                ptr_next = end_slot[PTR_W-1:0];
            end
        end else if (split) begin
            ptr_next      = '0;
            acc_done_next = 1'b1;
        end
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_be_next    = out_be_reg;
        out_addr_next  = out_addr_reg;
        if (out_valid_reg && wr_ready_i) begin
            out_valid_next = 1'b0;
        end
        if (xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = acc_data_reg;
            out_be_next    = acc_be_reg;
            out_addr_next  = acc_addr_reg;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            ptr_reg       <= '0;
            acc_data_reg  <= '0;
            acc_be_reg    <= '0;
            acc_addr_reg  <= '0;
            acc_done_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_be_reg    <= '0;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            acc_data_reg  <= acc_data_next;
            acc_be_reg    <= acc_be_next;
            acc_addr_reg  <= acc_addr_next;
            acc_done_reg  <= acc_done_next;
            out_data_reg  <= out_data_next;
            out_be_reg    <= out_be_next;
            out_addr_reg  <= out_addr_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign wr_valid_o = out_valid_reg;
    assign wr_addr_o  = out_addr_reg;
    assign wr_data_o  = out_data_reg;
    assign wr_be_o    = out_be_reg;
    assign busy_o     = (ptr_reg != '0) || acc_done_reg || out_valid_reg;

endmodule
